// File: rtl/fnd_display_scheduler_if.sv
// Request/display bundle between the FND requesters and the scheduler.
// The master side drives requests; the slave side drives the display outputs.
interface fnd_display_scheduler_if #(
    parameter int N_SRC = 4
);
    logic [N_SRC-1:0]   iReq;
    logic [8*N_SRC-1:0] iHexBus;
    logic [N_SRC-1:0]   iModeBus;
    logic               iHold;
    logic [7:0]         oHex;
    logic               oDisplayMode;
    logic [N_SRC-1:0]   oGrant;
    logic [N_SRC-1:0]   oAck;
    logic               oIdle;

    modport master (
        output iReq, iHexBus, iModeBus, iHold,
        input  oHex, oDisplayMode, oGrant, oAck, oIdle
    );

    modport slave (
        input  iReq, iHexBus, iModeBus, iHold,
        output oHex, oDisplayMode, oGrant, oAck, oIdle
    );
endinterface

// File: rtl/fnd_display_scheduler.sv
// Round-robin time-sharing of the two-digit FND display.
// Each grant snapshots the source value/mode and holds it for a fixed dwell.
module fnd_display_scheduler #(
    parameter int N_SRC     = 4,
    parameter int DWELL_CYC = 100_000_000,
    parameter int CNT_W     = 27
) (
    input  logic                    iCLK,
    input  logic                    iReset,
    fnd_display_scheduler_if.slave  bus
);
    localparam int PW = $clog2(N_SRC);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_ARB  = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_ptr;
    logic             r_ack;
    logic [7:0]       r_hex;
    logic             r_mode;
    logic [N_SRC-1:0] r_grant;

    logic             w_found;
    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_idx;
    int               w_j;
    logic [7:0]       w_hex_sel;
    logic [N_SRC-1:0] w_onehot;
    logic             w_last;

    // Scan starts one past the current owner and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_j     = 0;
        w_idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            w_j   = (int'(r_ptr) + i) % N_SRC;
            w_idx = PW'(w_j);
            if (!w_found && bus.iReq[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_hex_sel = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (PW'(k) == w_win) w_hex_sel = bus.iHexBus[8*k +: 8];
        end
    end

    assign w_onehot = {{(N_SRC-1){1'b0}}, 1'b1} << w_win;
    assign w_last   = (r_cnt == CNT_W'(DWELL_CYC - 1));

    always_ff @(posedge iCLK) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= PW'(N_SRC - 1);
            r_ack   <= 1'b0;
            r_hex   <= '0;
            r_mode  <= 1'b0;
            r_grant <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ARB: begin
                    r_ack <= 1'b0;
                    if (w_found) begin
                        r_state <= S_SHOW;
                        r_grant <= w_onehot;
                        r_hex   <= w_hex_sel;
                        r_mode  <= bus.iModeBus[w_win];
                        r_ptr   <= w_win;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_hex   <= '0;
                        r_mode  <= 1'b0;
                    end
                end
                S_SHOW: begin
                    // Early release wins over dwell completion, even on hold.
                    if (!bus.iReq[r_ptr]) begin
                        r_state <= S_ARB;
                        r_ack   <= 1'b0;
                    end else if (!bus.iHold) begin
                        if (w_last) begin
                            r_state <= S_ARB;
                            r_ack   <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                    r_hex   <= '0;
                    r_mode  <= 1'b0;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oHex         = r_hex;
    assign bus.oDisplayMode = r_mode;
    assign bus.oGrant       = r_grant;
    assign bus.oAck         = (r_state == S_ARB && r_ack) ? r_grant : '0;
    assign bus.oIdle        = (r_state == S_IDLE);
endmodule

// File: tb/tb_fnd_display_scheduler.sv
// Directed and random checks of fnd_display_scheduler against
// a cycle-level behavioural model of the grant/dwell rules.
module tb_fnd_display_scheduler;
    localparam int N  = 4;
    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fnd_display_scheduler_if #(.N_SRC(N)) bus();

    fnd_display_scheduler #(
        .N_SRC(N), .DWELL_CYC(DW), .CNT_W(3)
    ) dut (
        .iCLK(clk), .iReset(rst), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // model: phase 0 = nobody shown, 1 = showing, 2 = gap between grants
    int         m_phase;
    int         m_owner;
    int         m_done;
    int         m_last;
    bit         m_acked;
    logic [7:0] m_hex;
    logic       m_mode;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (bus.iReq[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int p;
        if (rst) begin
            m_phase = 0; m_owner = -1; m_done = 0;
            m_last = N - 1; m_acked = 0;
            m_hex = 8'h00; m_mode = 1'b0;
        end else if (m_phase == 1) begin
            if (!bus.iReq[m_owner]) begin
                m_phase = 2; m_acked = 0;
            end else if (!bus.iHold) begin
                m_done++;
                if (m_done == DW) begin
                    m_phase = 2; m_acked = 1;
                end
            end
        end else begin
            p = rr_pick();
            m_acked = 0;
            if (p >= 0) begin
                m_phase = 1; m_owner = p; m_done = 0; m_last = p;
                m_hex  = bus.iHexBus[8*p +: 8];
                m_mode = bus.iModeBus[p];
            end else begin
                m_phase = 0; m_owner = -1;
                m_hex = 8'h00; m_mode = 1'b0;
            end
        end
    endtask

    task automatic check_outs();
        logic [N-1:0] eg, ea;
        eg = (m_phase != 0) ? N'(1 << m_owner) : '0;
        ea = (m_phase == 2 && m_acked) ? N'(1 << m_owner) : '0;
        chk("grant", 32'(bus.oGrant), 32'(eg));
        chk("ack",   32'(bus.oAck),   32'(ea));
        chk("hex",   32'(bus.oHex),   32'(m_hex));
        chk("mode",  32'(bus.oDisplayMode), 32'(m_mode));
        chk("idle",  32'(bus.oIdle),  32'(m_phase == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iReq = '1;
        tick();
        chk("rst_idle", 32'(bus.oIdle), 32'd1);
        chk("rst_grant", 32'(bus.oGrant), 32'd0);
        tick();
        chk("rst_hex", 32'(bus.oHex), 32'd0);
        rst = 1'b0;
        bus.iReq = '0;
        tick();
        chk("post_rst_idle", 32'(bus.oIdle), 32'd1);
    endtask

    initial begin
        logic [N-1:0] gseq[$];
        logic [N-1:0] aseq[$];
        logic [N-1:0] prev;
        int n;
        bit seen;

        rst = 1'b1;
        bus.iReq = '0; bus.iHexBus = '0;
        bus.iModeBus = '0; bus.iHold = 1'b0;
        m_phase = 0; m_owner = -1; m_done = 0;
        m_last = N - 1; m_acked = 0;
        m_hex = 8'h00; m_mode = 1'b0;
        @(negedge clk);

        do_reset();
        chk("rst_ack", 32'(bus.oAck), 32'd0);
        chk("rst_mode", 32'(bus.oDisplayMode), 32'd0);

        // single source re-granted after each dwell
        bus.iHexBus = 32'h003C_0000;
        bus.iModeBus = 4'b0100;
        bus.iReq = 4'b0100;
        tick();
        chk("single_grant", 32'(bus.oGrant), 32'h4);
        chk("single_hex", 32'(bus.oHex), 32'h3C);
        chk("single_mode", 32'(bus.oDisplayMode), 32'd1);
        repeat (3) tick();
        tick();
        chk("single_ack", 32'(bus.oAck), 32'h4);
        tick();
        chk("single_regrant", 32'(bus.oGrant), 32'h4);
        chk("single_ack_off", 32'(bus.oAck), 32'h0);

        // round robin across all four
        do_reset();
        bus.iHexBus = 32'h4433_2211;
        bus.iModeBus = 4'b1010;
        bus.iReq = 4'b1111;
        prev = '0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.oGrant != prev && bus.oGrant != 0) gseq.push_back(bus.oGrant);
            if (bus.oAck != 0) aseq.push_back(bus.oAck);
            prev = bus.oGrant;
        end
        chk("rr_len", 32'(gseq.size()), 32'd5);
        chk("ack_len", 32'(aseq.size()), 32'd5);
        for (int i = 0; i < 5 && i < gseq.size(); i++)
            chk("rr_seq", 32'(gseq[i]), 32'(1 << (i % N)));
        for (int i = 0; i < 4 && i < aseq.size(); i++)
            chk("ack_seq", 32'(aseq[i]), 32'(1 << i));

        // snapshot of source 0
        do_reset();
        bus.iHexBus = 32'h0000_0025;
        bus.iReq = 4'b0001;
        tick();
        bus.iHexBus = 32'h0000_0099;
        repeat (4) tick();
        chk("snap_hold", 32'(bus.oHex), 32'h25);
        tick();
        chk("snap_new", 32'(bus.oHex), 32'h99);

        // early release of source 1 while source 2 waits
        do_reset();
        bus.iReq = 4'b0110;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (m_phase == 1 && m_owner == 1 && m_done == 1) begin
                bus.iReq = 4'b0100;
                tick();
                tick();
                chk("erel_noack", 32'(bus.oAck), 32'd0);
                tick();
                chk("erel_next", 32'(bus.oGrant), 32'h4);
                seen = 1;
            end
        end
        chk("erel_seen", 32'(seen), 32'd1);
        bus.iReq = '0;
        repeat (8) tick();
        chk("erel_idle", 32'(bus.oIdle), 32'd1);
        chk("erel_hex0", 32'(bus.oHex), 32'd0);

        // hold stretches the dwell to 7 shown cycles
        bus.iReq = 4'b0001;
        tick();
        chk("hold_grant", 32'(bus.oGrant), 32'h1);
        n = 0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            bus.iHold = (c < 3);
            tick();
            n++;
            if (bus.oAck != 0) seen = 1;
        end
        bus.iHold = 1'b0;
        chk("hold_len", 32'(n), 32'd7);

        // reset in the middle of a dwell
        bus.iReq = 4'b1111;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        chk("mrst_grant", 32'(bus.oGrant), 32'd0);
        chk("mrst_hex", 32'(bus.oHex), 32'd0);
        chk("mrst_idle", 32'(bus.oIdle), 32'd1);
        rst = 1'b0;
        bus.iReq = 4'b1010;
        tick();
        chk("mrst_first", 32'(bus.oGrant), 32'h2);

        // random traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 3) == 0) bus.iReq = N'($urandom);
            if ($urandom_range(0, 2) == 0) bus.iHexBus = $urandom;
            if ($urandom_range(0, 2) == 0) bus.iModeBus = N'($urandom);
            bus.iHold = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
